// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: per-channel flop-chain synchronizer, stability
// debouncer and registered single-cycle rise/fall event pulses.
module input_conditioner #(
    parameter int                  CHANNELS        = 4,
    parameter int                  STAGES          = 2,
    parameter int                  DEBOUNCE_CYCLES = 4,
    parameter logic [CHANNELS-1:0] RESET_LEVEL     = '0
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic [CHANNELS-1:0] value_i,
    output logic [CHANNELS-1:0] value_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [STAGES-1:0][CHANNELS-1:0] stage_q;
    logic [CHANNELS-1:0]             sync_s;
    logic [CHANNELS-1:0][CW-1:0]     cnt_q;
    logic [CHANNELS-1:0][CW-1:0]     cnt_d;
    logic [CHANNELS-1:0]             value_q;
    logic [CHANNELS-1:0]             value_d;
    logic [CHANNELS-1:0]             rise_q;
    logic [CHANNELS-1:0]             fall_q;

    // Synchronizer chain: plain shift register, no logic between stages.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            stage_q <= {STAGES{RESET_LEVEL}};
        end else begin
            stage_q <= {stage_q[STAGES-2:0], value_i};
        end
    end

    assign sync_s = stage_q[STAGES-1];

    // Debounce decision: any agreement clears the count; the last disagreeing
    // cycle adopts the synchronized level instead of incrementing.
    always_comb begin
        cnt_d   = '0;
        value_d = value_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (sync_s[c] == value_q[c]) begin
                cnt_d[c] = '0;
            end else if (cnt_q[c] == CNT_MAX) begin
                value_d[c] = sync_s[c];
                cnt_d[c]   = '0;
            end else begin
                cnt_d[c] = cnt_q[c] + CW'(1);
            end
        end
    end

    // Debounce state and event pulses, all cleared asynchronously by reset.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            value_q <= RESET_LEVEL;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            value_q <= value_d;
            rise_q  <= value_d & ~value_q;
            fall_q  <= ~value_d & value_q;
        end
    end

    assign value_o = value_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule
